// File: rtl/floo_id_remap_buffer.sv
// floo_id_remap_buffer: remaps wide request IDs onto ordered slots and restores ID and meta on responses
module floo_id_remap_buffer #(
  parameter int InIdWidth    = 4,
  parameter int OutIdWidth   = 3,
  parameter int MaxTxnsPerId = 4,
  parameter int MetaWidth    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [InIdWidth-1:0]  req_id_i,
  input  logic                  req_excl_i,
  input  logic [MetaWidth-1:0]  req_meta_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [OutIdWidth-1:0] req_id_o,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic [OutIdWidth-1:0] rsp_id_i,
  input  logic                  rsp_last_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [InIdWidth-1:0]  rsp_id_o,
  output logic [MetaWidth-1:0]  rsp_meta_o,
  output logic [OutIdWidth:0]   free_slots_o,
  output logic                  err_o
);
  localparam int NumSlots  = 2 ** OutIdWidth;
  localparam int CntWidth  = $clog2(MaxTxnsPerId + 1);
  localparam int FifoWidth = MaxTxnsPerId * MetaWidth;
  logic [CntWidth-1:0]   cnt_q   [NumSlots];
  logic [CntWidth-1:0]   cnt_d   [NumSlots];
  logic [InIdWidth-1:0]  owner_q [NumSlots];
  logic [FifoWidth-1:0]  fifo_q  [NumSlots];
  logic [FifoWidth-1:0]  fifo_d  [NumSlots];
  logic [NumSlots-1:0]   excl_q, push_vec, pop_vec;
  logic                  lock_q, hit, use_hit, free, can_accept, pop_fire, rsp_hit;
  logic [OutIdWidth-1:0] lock_slot_q, hit_slot, free_slot, slot;
  logic [OutIdWidth:0]   nfree;
  // Scan slots for an open same-ID slot, the lowest free slot and the free count
  always_comb begin
    hit       = 1'b0;
    hit_slot  = '0;
    free      = 1'b0;
    free_slot = '0;
    nfree     = '0;
    for (int s = NumSlots - 1; s >= 0; s--) begin
      if (cnt_q[s] == '0) begin
        free      = 1'b1;
        free_slot = OutIdWidth'(s);
        nfree     = nfree + (OutIdWidth + 1)'(1);
      end else if (!excl_q[s] && owner_q[s] == req_id_i) begin
        hit      = 1'b1;
        hit_slot = OutIdWidth'(s);
      end
    end
  end
  assign use_hit      = hit & ~req_excl_i;
  assign can_accept   = lock_q | (use_hit ? (cnt_q[hit_slot] < CntWidth'(MaxTxnsPerId)) : free);
  assign slot         = lock_q ? lock_slot_q : use_hit ? hit_slot : free_slot;
  assign req_valid_o  = req_valid_i & can_accept;
  assign req_ready_o  = req_ready_i & can_accept;
  assign req_id_o     = slot;
  assign free_slots_o = nfree;
  assign rsp_hit      = cnt_q[rsp_id_i] != '0;
  assign rsp_valid_o  = rsp_valid_i;
  assign rsp_ready_o  = rsp_ready_i;
  assign rsp_id_o     = rsp_hit ? owner_q[rsp_id_i] : '0;
  assign rsp_meta_o   = rsp_hit ? fifo_q[rsp_id_i][MetaWidth-1:0] : '0;
  assign pop_fire     = rsp_valid_i & rsp_ready_i & rsp_last_i;
  assign push_vec     = {NumSlots{req_valid_o & req_ready_i}} & (NumSlots'(1) << slot);
  assign pop_vec      = {NumSlots{pop_fire & rsp_hit}} & (NumSlots'(1) << rsp_id_i);
  // Per-slot FIFO shifts toward the head on pop; push writes behind the surviving entries
  always_comb begin
    for (int s = 0; s < NumSlots; s++) begin
      fifo_d[s] = pop_vec[s] ? fifo_q[s] >> MetaWidth : fifo_q[s];
      if (push_vec[s])
        fifo_d[s][(int'(cnt_q[s]) - int'(pop_vec[s])) * MetaWidth +: MetaWidth] = req_meta_i;
      cnt_d[s] = cnt_q[s] + CntWidth'(push_vec[s]) - CntWidth'(pop_vec[s]);
    end
  end
  // Slot state, request lock and sticky error register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NumSlots; s++) begin
        cnt_q[s]   <= '0;
        owner_q[s] <= '0;
        fifo_q[s]  <= '0;
      end
      excl_q      <= '0;
      lock_q      <= 1'b0;
      lock_slot_q <= '0;
      err_o       <= 1'b0;
    end else begin
      lock_q      <= req_valid_o & ~req_ready_i;
      lock_slot_q <= slot;
      err_o       <= err_o | (pop_fire & ~rsp_hit);
      for (int s = 0; s < NumSlots; s++) begin
        cnt_q[s]  <= cnt_d[s];
        fifo_q[s] <= fifo_d[s];
        if (push_vec[s]) begin
          owner_q[s] <= req_id_i;
          excl_q[s]  <= req_excl_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_floo_id_remap_buffer.sv
// tb_floo_id_remap_buffer: directed scenarios plus random traffic against a queue-based reference model
module tb_floo_id_remap_buffer;
  logic       clk_i = 1'b0, rst_i;
  logic       req_valid_i, req_ready_o, req_excl_i, req_valid_o, req_ready_i;
  logic [3:0] req_id_i;
  logic [7:0] req_meta_i;
  logic [2:0] req_id_o;
  logic       rsp_valid_i, rsp_ready_o, rsp_last_i, rsp_valid_o, rsp_ready_i;
  logic [2:0] rsp_id_i;
  logic [3:0] rsp_id_o;
  logic [7:0] rsp_meta_o;
  logic [3:0] free_slots_o;
  logic       err_o;

  floo_id_remap_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_id_i(req_id_i),
    .req_excl_i(req_excl_i), .req_meta_i(req_meta_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_id_o(req_id_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_id_i(rsp_id_i),
    .rsp_last_i(rsp_last_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_meta_o(rsp_meta_o), .free_slots_o(free_slots_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  int         mcnt [8];
  logic [3:0] mown [8];
  bit         mexc [8];
  logic [7:0] mq   [8][$];
  bit         merr, mlock, e_ok;
  int         mlslot, e_slot, e_free;
  logic [3:0] e_rid;
  logic [7:0] e_rmeta;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      mcnt[s] = 0; mown[s] = '0; mexc[s] = 0; mq[s].delete();
    end
    merr = 0; mlock = 0; mlslot = 0;
  endtask

  task automatic model_eval();
    int hit, fr, r;
    hit = -1; fr = -1; e_free = 0;
    for (int s = 0; s < 8; s++) begin
      if (mcnt[s] == 0) begin
        e_free++;
        if (fr < 0) fr = s;
      end else if (!mexc[s] && mown[s] == req_id_i) hit = s;
    end
    if (mlock) begin
      e_ok = 1; e_slot = mlslot;
    end else if (!req_excl_i && hit >= 0) begin
      e_ok = mcnt[hit] < 4; e_slot = hit;
    end else begin
      e_ok = fr >= 0; e_slot = (fr < 0) ? 0 : fr;
    end
    r = int'(rsp_id_i);
    if (mcnt[r] > 0) begin
      e_rid = mown[r]; e_rmeta = mq[r][0];
    end else begin
      e_rid = '0; e_rmeta = '0;
    end
  endtask

  task automatic model_step();
    int r;
    r = int'(rsp_id_i);
    if (rst_i) model_reset();
    else begin
      if (rsp_valid_i && rsp_ready_i && rsp_last_i) begin
        if (mcnt[r] > 0) begin
          mcnt[r]--;
          void'(mq[r].pop_front());
        end else merr = 1;
      end
      if (req_valid_i && e_ok && req_ready_i) begin
        mq[e_slot].push_back(req_meta_i);
        mcnt[e_slot]++;
        mown[e_slot] = req_id_i;
        mexc[e_slot] = req_excl_i;
      end
      mlock  = req_valid_i && e_ok && !req_ready_i;
      mlslot = e_slot;
    end
  endtask

  // Compare every DUT output with the model, then advance the model across the coming edge
  task automatic cyc();
    #1;
    model_eval();
    chk("req_valid_o", 32'(req_valid_o), 32'(req_valid_i & e_ok));
    chk("req_ready_o", 32'(req_ready_o), 32'(req_ready_i & e_ok));
    if (req_valid_i && e_ok) chk("req_id_o", 32'(req_id_o), 32'(e_slot));
    chk("rsp_valid_o", 32'(rsp_valid_o), 32'(rsp_valid_i));
    chk("rsp_ready_o", 32'(rsp_ready_o), 32'(rsp_ready_i));
    chk("rsp_id_o", 32'(rsp_id_o), 32'(e_rid));
    chk("rsp_meta_o", 32'(rsp_meta_o), 32'(e_rmeta));
    chk("free_slots_o", 32'(free_slots_o), 32'(e_free));
    chk("err_o", 32'(err_o), 32'(merr));
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_req(input logic v, input logic [3:0] id, input logic ex, input logic [7:0] m);
    req_valid_i = v; req_id_i = id; req_excl_i = ex; req_meta_i = m;
  endtask

  task automatic set_rsp(input logic v, input logic [2:0] id, input logic last);
    rsp_valid_i = v; rsp_id_i = id; rsp_last_i = last; rsp_ready_i = 1'b1;
  endtask

  task automatic idle();
    set_req(0, 4'd0, 0, 8'd0);
    set_rsp(0, 3'd0, 0);
    req_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("reset_free", 32'(free_slots_o), 32'd8);
    chk("reset_err", 32'(err_o), 32'd0);
    #1;
    set_req(1, 4'd5, 0, 8'hA1);
    #1;
    chk("first_slot", 32'(req_id_o), 32'd0);
    chk("first_ready", 32'(req_ready_o), 32'd1);
    cyc();
    set_req(0, 4'd0, 0, 8'd0);
    set_rsp(1, 3'd0, 1);
    #1;
    chk("first_rsp_id", 32'(rsp_id_o), 32'd5);
    chk("first_rsp_meta", 32'(rsp_meta_o), 32'hA1);
    cyc();
    idle();
    for (int i = 0; i < 4; i++) begin
      set_req(1, 4'd5, 0, 8'(8'h10 + i));
      cyc();
    end
    set_req(1, 4'd5, 0, 8'h14);
    #1;
    chk("full_stall", 32'(req_ready_o), 32'd0);
    cyc();
    set_rsp(1, 3'd0, 1);
    #1;
    chk("full_pop_no_bypass", 32'(req_ready_o), 32'd0);
    chk("fifo_head0", 32'(rsp_meta_o), 32'h10);
    cyc();
    set_rsp(0, 3'd0, 0);
    #1;
    chk("full_resume", 32'(req_ready_o), 32'd1);
    chk("full_resume_slot", 32'(req_id_o), 32'd0);
    cyc();
    set_req(0, 4'd0, 0, 8'd0);
    for (int i = 1; i <= 4; i++) begin
      set_rsp(1, 3'd0, 1);
      #1;
      chk("fifo_order", 32'(rsp_meta_o), 32'(8'h10 + i));
      cyc();
    end
    idle();
    for (int i = 1; i <= 8; i++) begin
      set_req(1, 4'(i), 0, 8'(i));
      cyc();
    end
    set_req(1, 4'd9, 0, 8'h99);
    #1;
    chk("all_full_free", 32'(free_slots_o), 32'd0);
    chk("all_full_stall", 32'(req_ready_o), 32'd0);
    set_rsp(1, 3'd3, 1);
    #1;
    chk("freed_not_yet", 32'(req_ready_o), 32'd0);
    cyc();
    set_rsp(0, 3'd0, 0);
    #1;
    chk("freed_grant", 32'(req_ready_o), 32'd1);
    chk("freed_slot3", 32'(req_id_o), 32'd3);
    cyc();
    do_reset();
    set_req(1, 4'd5, 0, 8'h01);
    cyc();
    set_req(1, 4'd5, 1, 8'h02);
    #1;
    chk("excl_private", 32'(req_id_o), 32'd1);
    cyc();
    set_req(1, 4'd5, 0, 8'h03);
    #1;
    chk("hit_not_excl", 32'(req_id_o), 32'd0);
    cyc();
    do_reset();
    set_req(1, 4'd5, 0, 8'h05);
    cyc();
    set_req(1, 4'd7, 0, 8'h07);
    cyc();
    set_req(1, 4'd9, 0, 8'h09);
    req_ready_i = 1'b0;
    #1;
    chk("lock_slot_first", 32'(req_id_o), 32'd2);
    cyc();
    set_rsp(1, 3'd0, 1);
    #1;
    chk("lock_slot_pop", 32'(req_id_o), 32'd2);
    cyc();
    set_rsp(0, 3'd0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lock_slot_hold", 32'(req_id_o), 32'd2);
      cyc();
    end
    req_ready_i = 1'b1;
    #1;
    chk("lock_handshake", 32'(req_id_o), 32'd2);
    cyc();
    do_reset();
    set_rsp(1, 3'd2, 1);
    cyc();
    set_rsp(0, 3'd0, 0);
    #1;
    chk("err_set", 32'(err_o), 32'd1);
    chk("err_no_cnt_change", 32'(free_slots_o), 32'd8);
    cyc();
    set_req(1, 4'd3, 0, 8'h33);
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    idle();
    #1;
    chk("midrst_err", 32'(err_o), 32'd0);
    chk("midrst_free", 32'(free_slots_o), 32'd8);
    chk("midrst_rsp_id", 32'(rsp_id_o), 32'd0);
    cyc();
    for (int n = 0; n < 4000; n++) begin
      if (!mlock) begin
        req_valid_i = 1'($urandom_range(0, 1));
        req_id_i    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
        req_excl_i  = $urandom_range(0, 9) == 0;
        req_meta_i  = 8'($urandom);
      end
      req_ready_i = $urandom_range(0, 3) != 0;
      rsp_valid_i = 1'($urandom_range(0, 1));
      rsp_ready_i = $urandom_range(0, 3) != 0;
      rsp_last_i  = 1'($urandom_range(0, 1));
      rsp_id_i    = 3'($urandom_range(0, 7));
      rst_i       = $urandom_range(0, 499) == 0;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
